// File: rtl/spi_slave_pkg.sv
// Shared widths, frame constants and state type for the SPI register slave.
package spi_slave_pkg;

  localparam int unsigned ADDR_LEN   = 8;
  localparam int unsigned WAIT_LEN   = 2;
  localparam int unsigned WORD_LEN   = 16;
  localparam int unsigned FRAME_BITS = 1 + ADDR_LEN + WAIT_LEN + WORD_LEN;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic {
    FRAME_IDLE,
    FRAME_ACTIVE
  } frame_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin with single-cycle edge pulses.
module spi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // Resynchronise the pin and keep one delayed copy for edge detection.
  // Reset to 0 so an SS pin held low across reset produces no falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= d;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 slave front-end decoding {rw, addr, wait, data} frames into
// single-cycle register write/read strobes; returns read data on MISO.
module spi_reg_slave
  import spi_slave_pkg::*;
#(
  parameter int unsigned ADDR_LEN = spi_slave_pkg::ADDR_LEN,
  parameter int unsigned WAIT_LEN = spi_slave_pkg::WAIT_LEN,
  parameter int unsigned WORD_LEN = spi_slave_pkg::WORD_LEN
) (
  input  logic                i_master_clock,
  input  logic                i_rst,
  input  logic [WORD_LEN-1:0] data_word_send,
  input  logic                i_SCLK,
  input  logic                i_SS,
  input  logic                i_MOSI,
  output logic                o_MISO,
  output logic                reg_operate,
  output logic                spi_rw,
  output logic                spi_write,
  output logic                spi_read,
  output logic [ADDR_LEN-1:0] spi_addr,
  output logic [WORD_LEN-1:0] spi_data
);

  localparam int unsigned FRAME_LEN = 1 + ADDR_LEN + WAIT_LEN + WORD_LEN;
  localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 2);
  localparam int unsigned SHIFT_W   = (WORD_LEN > ADDR_LEN) ? WORD_LEN : ADDR_LEN;

  localparam logic [CNT_W-1:0] CNT_ZERO     = '0;
  localparam logic [CNT_W-1:0] CNT_ADDR_PRE = CNT_W'(ADDR_LEN);
  localparam logic [CNT_W-1:0] CNT_MISO     = CNT_W'(1 + ADDR_LEN + WAIT_LEN);
  localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(FRAME_LEN + 1);

  logic sclk_rise;
  logic sclk_fall;
  logic ss_rise;
  logic ss_fall;
  logic mosi_meta;
  logic mosi_s;

  frame_state_t          state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [SHIFT_W-1:0]    shift_reg;
  logic [WORD_LEN-1:0]   miso_sr;

  spi_sync_edge u_sclk_sync (
    .clk  (i_master_clock),
    .rst  (i_rst),
    .d    (i_SCLK),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge u_ss_sync (
    .clk  (i_master_clock),
    .rst  (i_rst),
    .d    (i_SS),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  // Plain two-flop synchroniser for MOSI, same latency as the SCLK edges.
  always_ff @(posedge i_master_clock) begin
    if (i_rst) begin
      mosi_meta <= 1'b0;
      mosi_s    <= 1'b0;
    end else begin
      mosi_meta <= i_MOSI;
      mosi_s    <= mosi_meta;
    end
  end

  // Frame FSM: bit counting, field capture, MISO shifting and strobes.
  // ACTIVE spans SS fall to SS rise, so it doubles as the "SS low" qualifier.
  always_ff @(posedge i_master_clock) begin
    if (i_rst) begin
      state       <= FRAME_IDLE;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      miso_sr     <= '0;
      o_MISO      <= 1'b0;
      spi_rw      <= RW_WRITE;
      spi_addr    <= '0;
      spi_data    <= '0;
      spi_write   <= 1'b0;
      spi_read    <= 1'b0;
      reg_operate <= 1'b0;
    end else begin
      spi_write   <= 1'b0;
      spi_read    <= 1'b0;
      reg_operate <= 1'b0;
      case (state)
        FRAME_IDLE: begin
          o_MISO <= 1'b0;
          if (ss_fall) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            state     <= FRAME_ACTIVE;
          end
        end
        FRAME_ACTIVE: begin
          if (ss_rise) begin
            state  <= FRAME_IDLE;
            o_MISO <= 1'b0;
            if (bit_cnt == CNT_FULL && spi_rw == RW_WRITE) begin
              spi_data    <= shift_reg[WORD_LEN-1:0];
              spi_write   <= 1'b1;
              reg_operate <= 1'b1;
            end
          end else if (sclk_rise) begin
            shift_reg <= {shift_reg[SHIFT_W-2:0], mosi_s};
            if (bit_cnt != CNT_SAT) begin
              bit_cnt <= bit_cnt + 1'b1;
            end
            // Compare against the pre-increment count: this edge samples bit_cnt+1.
            if (bit_cnt == CNT_ZERO) begin
              spi_rw <= mosi_s;
            end
            if (bit_cnt == CNT_ADDR_PRE) begin
              spi_addr <= {shift_reg[ADDR_LEN-2:0], mosi_s};
              if (spi_rw == RW_READ) begin
                spi_read    <= 1'b1;
                reg_operate <= 1'b1;
              end
            end
          end else if (sclk_fall) begin
            if (spi_rw == RW_READ && bit_cnt == CNT_MISO) begin
              miso_sr <= {data_word_send[WORD_LEN-2:0], 1'b0};
              o_MISO  <= data_word_send[WORD_LEN-1];
            end else if (spi_rw == RW_READ && bit_cnt > CNT_MISO && bit_cnt < CNT_FULL) begin
              miso_sr <= {miso_sr[WORD_LEN-2:0], 1'b0};
              o_MISO  <= miso_sr[WORD_LEN-1];
            end else begin
              o_MISO <= 1'b0;
            end
          end
        end
        default: state <= FRAME_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_slave.sv
// Randomised self-checking bench for spi_reg_slave with a frame-level model.
module tb_spi_reg_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data_word_send;
  logic        sclk, ss, mosi;
  logic        miso, reg_operate, spi_rw, spi_write, spi_read;
  logic [7:0]  spi_addr;
  logic [15:0] spi_data;

  int n_checks = 0;
  int n_pass   = 0;

  // strobe monitor results
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  logic [7:0]  wr_addr, rd_addr;
  logic [15:0] wr_data;

  // reference model state
  logic        exp_rw;
  logic [7:0]  exp_addr;
  logic [15:0] exp_data;

  always #5 clk = ~clk;

  spi_reg_slave #(.ADDR_LEN(8), .WAIT_LEN(2), .WORD_LEN(16)) dut (
    .i_master_clock (clk),
    .i_rst          (rst),
    .data_word_send (data_word_send),
    .i_SCLK         (sclk),
    .i_SS           (ss),
    .i_MOSI         (mosi),
    .o_MISO         (miso),
    .reg_operate    (reg_operate),
    .spi_rw         (spi_rw),
    .spi_write      (spi_write),
    .spi_read       (spi_read),
    .spi_addr       (spi_addr),
    .spi_data       (spi_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Record strobes and check their relationship whenever any is active.
  always @(negedge clk) begin
    if (!rst && (spi_write || spi_read || reg_operate)) begin
      check("reg_operate", reg_operate, spi_write | spi_read);
      check("exclusive", spi_write & spi_read, 1'b0);
      if (spi_write) begin
        wr_cnt++;
        wr_addr = spi_addr;
        wr_data = spi_data;
      end
      if (spi_read) begin
        rd_cnt++;
        rd_addr = spi_addr;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] mk(input logic rw, input logic [7:0] addr, input logic [15:0] data);
    return {5'b0, rw, addr, 2'b00, data};
  endfunction

  // Drive n bits of word (MSB first, bit n-1 first) as one SS-framed transfer,
  // then compare DUT against the frame-level model.
  task automatic send_frame(input logic [31:0] word, input int n, input logic [15:0] host);
    int          w0, r0;
    logic [31:0] rx, exp_rx;
    logic        rw, exp_wr, exp_rd;
    w0 = wr_cnt;
    r0 = rd_cnt;
    rx = '0;
    data_word_send = host;
    ss = 1'b0;
    wait_clk(4);
    for (int i = 0; i < n; i++) begin
      mosi = word[n-1-i];
      wait_clk(4);
      rx[i] = miso;
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
    mosi = 1'b0;
    wait_clk(4);
    ss = 1'b1;
    wait_clk(8);

    rw     = word[n-1];
    exp_rw = rw;
    exp_rd = (n >= 9) && rw;
    exp_wr = (n == 27) && !rw;
    if (n >= 9) exp_addr = word[n-2 -: 8];
    if (exp_wr) exp_data = word[15:0];
    exp_rx = '0;
    for (int i = 0; i < n; i++)
      if (rw && i >= 11 && i <= 26) exp_rx[i] = host[26-i];

    check("write_count", wr_cnt - w0, exp_wr ? 1 : 0);
    check("read_count", rd_cnt - r0, exp_rd ? 1 : 0);
    check("spi_rw", spi_rw, exp_rw);
    check("spi_addr", spi_addr, exp_addr);
    check("spi_data", spi_data, exp_data);
    check("miso", rx, exp_rx);
    if (exp_rd) check("read_addr", rd_addr, exp_addr);
    if (exp_wr) begin
      check("write_addr", wr_addr, exp_addr);
      check("write_data", wr_data, exp_data);
    end
  endtask

  initial begin
    logic [31:0] w;
    int          lens [9] = '{27, 27, 27, 26, 28, 30, 9, 12, 5};
    rst = 1'b1; sclk = 1'b0; ss = 1'b1; mosi = 1'b0; data_word_send = '0;
    exp_rw = 1'b0; exp_addr = '0; exp_data = '0;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(4);
    check("rst_miso", miso, 1'b0);
    check("rst_rw", spi_rw, 1'b0);
    check("rst_addr", spi_addr, 8'h00);
    check("rst_data", spi_data, 16'h0000);
    check("rst_strobes", {reg_operate, spi_write, spi_read}, 3'b000);

    // directed write and read
    send_frame(mk(1'b0, 8'h84, 16'h0000), 27, 16'h1234);
    send_frame(mk(1'b1, 8'h82, 16'h0002), 27, 16'hFFF5);
    send_frame(mk(1'b0, 8'h10, 16'hBEEF), 27, 16'h0000);
    // truncated write: data must stay at previous value
    send_frame(mk(1'b0, 8'h7F, 16'hA5A5) >> 1, 26, 16'h0000);

    // reset in the middle of a read frame
    w = mk(1'b1, 8'hC3, 16'h0000);
    ss = 1'b0;
    wait_clk(4);
    for (int i = 0; i < 12; i++) begin
      mosi = w[26-i];
      wait_clk(4);
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_outputs", {miso, reg_operate, spi_write, spi_read, spi_rw}, 5'b0);
    check("midrst_addr", spi_addr, 8'h00);
    check("midrst_data", spi_data, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    exp_rw = 1'b0; exp_addr = '0; exp_data = '0;
    ss = 1'b1;
    wait_clk(8);
    send_frame(mk(1'b0, 8'h80, 16'h0005), 27, 16'h0000);

    // ten consecutive frames: 2 writes / 2 reads, descending addresses
    for (int k = 0; k < 10; k++)
      send_frame(mk(((k / 2) % 2) == 1, 8'(8'h84 - k), 16'($urandom)), 27, 16'($urandom));

    // random frame lengths and contents
    for (int k = 0; k < 20; k++)
      send_frame($urandom, lens[$urandom_range(0, 8)], 16'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
